pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Central stall/flush controller for the five-stage pipeline. It drives the `load` and `buffer_sel` inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB buffers, plus the PC load/redirect. Its decisions come from instruction and data cache handshakes, EX-stage branch resolution and load-use detection. It tracks cache responses that arrive while the pipeline is frozen, so no response is lost or re-requested.

## Interface
- No parameters.
- `clk` in 1: pipeline clock.
- `rst` in 1: reset, asynchronous, active-high.
- `i_resp` in 1: instruction cache response for the current fetch.
- `d_req` in 1: the valid MEM-stage packet is a load or store.
- `d_resp` in 1: data cache response for the MEM-stage access.
- `ex_valid` in 1: EX packet valid.
- `ex_mispredict` in 1: EX packet `correct_pc_prediction` == 0.
- `ex_is_load` in 1: EX packet is a load.
- `ex_rd` in 5: EX destination register.
- `id_valid` in 1: ID packet valid.
- `id_rs1`, `id_rs2` in 5 each: ID source registers.
- `id_use_rs1`, `id_use_rs2` in 1 each: ID reads rs1/rs2.
- `imem_req` out 1: issue or continue the instruction fetch.
- `dmem_req` out 1: issue or continue the data access.
- `pc_load` out 1: PC register load.
- `pc_redirect` out 1: PC input selects the EX `next_pc` instead of the predicted PC.
- `ifid_load`, `idex_load`, `exmem_load`, `memwb_load` out 1 each: buffer load enables.
- `ifid_sel`, `idex_sel`, `exmem_sel`, `memwb_sel` out `buffer_load_mux::buffer_sel_t`: buffer merge selects.
- `perf_imiss`, `perf_dmiss`, `perf_bubble`, `perf_flush` out 32 each: event counters (see Configuration).

## Operation
- Internal flags:
  - `if_done`: instruction response already captured during the current stall.
  - `mem_done`: data response already captured during the current stall.
- Derived terms:
  - `if_ok` = `i_resp | if_done`
  - `mem_ok` = `!d_req | d_resp | mem_done`
  - `advance` = `if_ok & mem_ok`
- `imem_req` = `!if_done`; `dmem_req` = `d_req & !mem_done`. A captured access is never reissued.
- Flag updates on each clock:
  - If `advance`: clear both flags.
  - Otherwise: `if_done` |= `i_resp`; `mem_done` |= `d_req & d_resp`.
- Hazard terms:
  - `flush` = `ex_valid & ex_mispredict`
  - `luse` = `ex_valid & ex_is_load & ex_rd != 0 & id_valid & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd))`
- Output priority when `advance` = 1, evaluated in this order:
  - **flush:** `pc_load` = 1, `pc_redirect` = 1. IF/ID and ID/EX load `load_invalid`. EX/MEM loads `load_exmem`; MEM/WB loads `load_memwb`. `luse` is ignored.
  - **luse:** `pc_load` = 0. IF/ID holds (`load` = 0, `use_old`). ID/EX loads `load_invalid` (bubble). EX/MEM and MEM/WB advance.
  - **normal:** `pc_load` = 1, `pc_redirect` = 0. All four buffers load with `load_ifid`/`load_idex`/`load_exmem`/`load_memwb` respectively.
- When `advance` = 0:
  - All `*_load` and `pc_load` are 0.
  - All sels are `use_old`; `pc_redirect` is 0.
  - `flush` and `luse` are deferred; they are re-evaluated on the advancing cycle.

## Timing
- Load, sel and request outputs are combinational from inputs and flags; flags and counters are registered.
- Reset values:
  - Flags 0, so `imem_req` = 1.
  - All loads 0 and all sels `use_old` while `rst` is high.
  - Counters 0.
- A single-cycle cache hit (`i_resp` = 1 and `mem_ok` = 1 in the same cycle) advances in that cycle with no stall.
- Simultaneous misses: the pipeline stays frozen until both responses have been seen, in either order. Each side's response is latched by its flag the cycle it arrives.
- Responses arriving in the same cycle as `advance` are consumed directly and do not set flags.
- `rst` asserted mid-stall: flags clear asynchronously and any pending captured response is discarded.

## Configuration
- `PIPE_CTRL_PERF_EN` defined: four 32-bit saturating counters, each incremented once per clock:
  - `perf_imiss`: `!advance & !if_ok`
  - `perf_dmiss`: `!advance & if_ok & !mem_ok`
  - `perf_bubble`: `advance & luse & !flush`
  - `perf_flush`: `advance & flush`
- Not defined: counter registers are absent and all `perf_*` outputs are tied to 0.

## Test plan
- **Reset release, hits:** `i_resp` = 1, `d_req` = 0 every cycle → every cycle all buffers load with their stage sels, `pc_load` = 1, `pc_redirect` = 0.
- **I-miss of 3 cycles:** `i_resp` low for 3 cycles → all loads 0 for 3 cycles, `imem_req` = 1 throughout, advance on the 4th cycle; `perf_imiss` = 3.
- **Overlapped misses:** `i_resp` at cycle 2, `d_resp` at cycle 5 → `if_done` = 1 over cycles 3–5, `imem_req` = 0 over cycles 3–5, single advance at cycle 5, flags 0 at cycle 6.
- **Load-use:** EX load with `ex_rd` = 5, ID with `id_use_rs1` = 1, `id_rs1` = 5 → `pc_load` = 0, `ifid_load` = 0, `idex_sel` = `load_invalid`, `exmem_sel` = `load_exmem`; same check with `ex_rd` = 0 → no bubble.
- **Mispredict plus load-use in the same cycle:** `ex_mispredict` = 1 → `pc_redirect` = 1, `ifid_sel` and `idex_sel` = `load_invalid`, `perf_flush` = 1, `perf_bubble` unchanged.
- **Async reset mid-stall:** `rst` pulsed between clock edges with `if_done` = 1 → flags and counters 0 immediately, `imem_req` = 1.

Source files
------------

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_ctrl
// Purpose  : Stall/flush controller for the five-stage pipeline; holds cache
//            responses seen during a freeze. Optional counters: PIPE_CTRL_PERF_EN.
// Revision : 1.0
// ============================================================================

package buffer_load_mux;
    typedef enum logic [2:0] {
        use_old      = 3'd0,
        load_invalid = 3'd1,
        load_ifid    = 3'd2,
        load_idex    = 3'd3,
        load_exmem   = 3'd4,
        load_memwb   = 3'd5
    } buffer_sel_t;
endpackage

module pipeline_ctrl (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_resp,
    input  logic                         d_req,
    input  logic                         d_resp,
    input  logic                         ex_valid,
    input  logic                         ex_mispredict,
    input  logic                         ex_is_load,
    input  logic [4:0]                   ex_rd,
    input  logic                         id_valid,
    input  logic [4:0]                   id_rs1,
    input  logic [4:0]                   id_rs2,
    input  logic                         id_use_rs1,
    input  logic                         id_use_rs2,
    output logic                         imem_req,
    output logic                         dmem_req,
    output logic                         pc_load,
    output logic                         pc_redirect,
    output logic                         ifid_load,
    output logic                         idex_load,
    output logic                         exmem_load,
    output logic                         memwb_load,
    output buffer_load_mux::buffer_sel_t ifid_sel,
    output buffer_load_mux::buffer_sel_t idex_sel,
    output buffer_load_mux::buffer_sel_t exmem_sel,
    output buffer_load_mux::buffer_sel_t memwb_sel,
    output logic [31:0]                  perf_imiss,
    output logic [31:0]                  perf_dmiss,
    output logic [31:0]                  perf_bubble,
    output logic [31:0]                  perf_flush
);
    import buffer_load_mux::*;

    logic if_done_q, if_done_d;
    logic mem_done_q, mem_done_d;
    logic if_ok, mem_ok, advance;
    logic flush, luse, rs1_hit, rs2_hit;

    always_comb begin
        if_ok   = i_resp | if_done_q;
        mem_ok  = !d_req | d_resp | mem_done_q;
        advance = if_ok & mem_ok;
        flush   = ex_valid & ex_mispredict;
        rs1_hit = id_use_rs1 & (id_rs1 == ex_rd);
        rs2_hit = id_use_rs2 & (id_rs2 == ex_rd);
        luse    = ex_valid & ex_is_load & (ex_rd != 5'd0) & id_valid & (rs1_hit | rs2_hit);
    end

    // A response seen while frozen is remembered until the pipeline finally moves.
    always_comb begin
        if_done_d  = if_done_q;
        mem_done_d = mem_done_q;
        if (advance) begin
            if_done_d  = 1'b0;
            mem_done_d = 1'b0;
        end else begin
            if_done_d  = if_done_q | i_resp;
            mem_done_d = mem_done_q | (d_req & d_resp);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_done_q  <= 1'b0;
            mem_done_q <= 1'b0;
        end else begin
            if_done_q  <= if_done_d;
            mem_done_q <= mem_done_d;
        end
    end

    always_comb begin
        imem_req    = !if_done_q;
        dmem_req    = d_req & !mem_done_q;
        pc_load     = 1'b0;
        pc_redirect = 1'b0;
        ifid_load   = 1'b0;
        idex_load   = 1'b0;
        exmem_load  = 1'b0;
        memwb_load  = 1'b0;
        ifid_sel    = use_old;
        idex_sel    = use_old;
        exmem_sel   = use_old;
        memwb_sel   = use_old;
        if (advance && !rst) begin
            exmem_load = 1'b1;
            memwb_load = 1'b1;
            exmem_sel  = load_exmem;
            memwb_sel  = load_memwb;
            if (flush) begin
                pc_load     = 1'b1;
                pc_redirect = 1'b1;
                ifid_load   = 1'b1;
                idex_load   = 1'b1;
                ifid_sel    = load_invalid;
                idex_sel    = load_invalid;
            end else if (luse) begin
                idex_load = 1'b1;
                idex_sel  = load_invalid;
            end else begin
                pc_load   = 1'b1;
                ifid_load = 1'b1;
                idex_load = 1'b1;
                ifid_sel  = load_ifid;
                idex_sel  = load_idex;
            end
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] imiss_q, imiss_d, dmiss_q, dmiss_d;
    logic [31:0] bubble_q, bubble_d, flush_cnt_q, flush_cnt_d;
    logic        ev_imiss, ev_dmiss, ev_bubble, ev_flush;

    always_comb begin
        ev_imiss    = !advance & !if_ok;
        ev_dmiss    = !advance & if_ok & !mem_ok;
        ev_bubble   = advance & luse & !flush;
        ev_flush    = advance & flush;
        imiss_d     = (ev_imiss  && imiss_q     != 32'hFFFF_FFFF) ? imiss_q     + 32'd1 : imiss_q;
        dmiss_d     = (ev_dmiss  && dmiss_q     != 32'hFFFF_FFFF) ? dmiss_q     + 32'd1 : dmiss_q;
        bubble_d    = (ev_bubble && bubble_q    != 32'hFFFF_FFFF) ? bubble_q    + 32'd1 : bubble_q;
        flush_cnt_d = (ev_flush  && flush_cnt_q != 32'hFFFF_FFFF) ? flush_cnt_q + 32'd1 : flush_cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            imiss_q     <= 32'd0;
            dmiss_q     <= 32'd0;
            bubble_q    <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            imiss_q     <= imiss_d;
            dmiss_q     <= dmiss_d;
            bubble_q    <= bubble_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign perf_imiss  = imiss_q;
    assign perf_dmiss  = dmiss_q;
    assign perf_bubble = bubble_q;
    assign perf_flush  = flush_cnt_q;
`else
    assign perf_imiss  = 32'd0;
    assign perf_dmiss  = 32'd0;
    assign perf_bubble = 32'd0;
    assign perf_flush  = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_ctrl
// Purpose  : Directed scoreboard bench for pipeline_ctrl.
// Revision : 1.0
// ============================================================================

module tb_pipeline_ctrl;
    localparam logic [2:0] S_OLD   = 3'(buffer_load_mux::use_old);
    localparam logic [2:0] S_INV   = 3'(buffer_load_mux::load_invalid);
    localparam logic [2:0] S_IFID  = 3'(buffer_load_mux::load_ifid);
    localparam logic [2:0] S_IDEX  = 3'(buffer_load_mux::load_idex);
    localparam logic [2:0] S_EXMEM = 3'(buffer_load_mux::load_exmem);
    localparam logic [2:0] S_MEMWB = 3'(buffer_load_mux::load_memwb);
    localparam int K_STALL = 0, K_NORM = 1, K_LUSE = 2, K_FLUSH = 3;
`ifdef PIPE_CTRL_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic clk, rst;
    logic i_resp, d_req, d_resp;
    logic ex_valid, ex_mispredict, ex_is_load, id_valid, id_use_rs1, id_use_rs2;
    logic [4:0] ex_rd, id_rs1, id_rs2;
    logic imem_req, dmem_req, pc_load, pc_redirect;
    logic ifid_load, idex_load, exmem_load, memwb_load;
    buffer_load_mux::buffer_sel_t ifid_sel, idex_sel, exmem_sel, memwb_sel;
    logic [31:0] perf_imiss, perf_dmiss, perf_bubble, perf_flush;

    typedef struct {
        logic [147:0] v;
        string        name;
    } exp_t;
    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    pipeline_ctrl dut (
        .clk(clk), .rst(rst), .i_resp(i_resp), .d_req(d_req), .d_resp(d_resp),
        .ex_valid(ex_valid), .ex_mispredict(ex_mispredict), .ex_is_load(ex_is_load),
        .ex_rd(ex_rd), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .imem_req(imem_req), .dmem_req(dmem_req), .pc_load(pc_load), .pc_redirect(pc_redirect),
        .ifid_load(ifid_load), .idex_load(idex_load), .exmem_load(exmem_load), .memwb_load(memwb_load),
        .ifid_sel(ifid_sel), .idex_sel(idex_sel), .exmem_sel(exmem_sel), .memwb_sel(memwb_sel),
        .perf_imiss(perf_imiss), .perf_dmiss(perf_dmiss), .perf_bubble(perf_bubble), .perf_flush(perf_flush)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] pv(input int n);
        return PERF_ON ? 32'(n) : 32'd0;
    endfunction

    function automatic logic [147:0] mk(input int kind, input logic im_r, input logic dm_r,
                                        input int a, input int b, input int c, input int d);
        logic [3:0]  ld;
        logic [11:0] sl;
        logic        pl, pr;
        pl = 1'b0; pr = 1'b0; ld = 4'b0000; sl = {S_OLD, S_OLD, S_OLD, S_OLD};
        case (kind)
            K_NORM:  begin pl = 1'b1; ld = 4'b1111; sl = {S_IFID, S_IDEX, S_EXMEM, S_MEMWB}; end
            K_LUSE:  begin ld = 4'b0111; sl = {S_OLD, S_INV, S_EXMEM, S_MEMWB}; end
            K_FLUSH: begin pl = 1'b1; pr = 1'b1; ld = 4'b1111; sl = {S_INV, S_INV, S_EXMEM, S_MEMWB}; end
            default: ;
        endcase
        return {im_r, dm_r, pl, pr, ld, sl, pv(a), pv(b), pv(c), pv(d)};
    endfunction

    function automatic logic [147:0] got_vec();
        return {imem_req, dmem_req, pc_load, pc_redirect,
                ifid_load, idex_load, exmem_load, memwb_load,
                3'(ifid_sel), 3'(idex_sel), 3'(exmem_sel), 3'(memwb_sel),
                perf_imiss, perf_dmiss, perf_bubble, perf_flush};
    endfunction

    // Monitor: compare one queued expectation against the outputs each negedge.
    initial begin
        exp_t        e;
        logic [147:0] g;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                g = got_vec();
                checks++;
                if (g !== e.v) begin
                    errors++;
                    $display("FAIL %s got=%h exp=%h", e.name, g, e.v);
                end
            end
        end
    end

    task automatic mem_in(input logic i, input logic dq, input logic dr);
        i_resp = i; d_req = dq; d_resp = dr;
    endtask

    task automatic haz(input logic ev, input logic mis, input logic ld, input logic [4:0] rd,
                       input logic iv, input logic [4:0] r1, input logic [4:0] r2,
                       input logic u1, input logic u2);
        ex_valid = ev; ex_mispredict = mis; ex_is_load = ld; ex_rd = rd;
        id_valid = iv; id_rs1 = r1; id_rs2 = r2; id_use_rs1 = u1; id_use_rs2 = u2;
    endtask

    task automatic push_exp(input logic [147:0] v, input string n);
        sb.push_back('{v: v, name: n});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic [147:0] v, input string n);
        push_exp(v, n);
        tick();
    endtask

    initial begin
        rst = 1'b1;
        mem_in(1'b0, 1'b0, 1'b0);
        haz(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();

        // Reset held: everything frozen, fetch requested.
        mem_in(1'b1, 1'b0, 1'b0);
        step(mk(K_STALL, 1, 0, 0, 0, 0, 0), "reset_state");
        rst = 1'b0;

        for (int k = 0; k < 3; k++) step(mk(K_NORM, 1, 0, 0, 0, 0, 0), "hit_stream");

        // Three-cycle instruction miss.
        mem_in(1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) step(mk(K_STALL, 1, 0, k, 0, 0, 0), "imiss_stall");
        mem_in(1'b1, 1'b0, 1'b0);
        step(mk(K_NORM, 1, 0, 3, 0, 0, 0), "imiss_advance");

        // Overlapped misses, instruction response first.
        mem_in(1'b0, 1'b1, 1'b0);
        step(mk(K_STALL, 1, 1, 3, 0, 0, 0), "ovl_both_miss");
        mem_in(1'b1, 1'b1, 1'b0);
        step(mk(K_STALL, 1, 1, 4, 0, 0, 0), "ovl_iresp");
        mem_in(1'b0, 1'b1, 1'b0);
        step(mk(K_STALL, 0, 1, 4, 1, 0, 0), "ovl_ifdone_c3");
        step(mk(K_STALL, 0, 1, 4, 2, 0, 0), "ovl_ifdone_c4");
        mem_in(1'b0, 1'b1, 1'b1);
        step(mk(K_NORM, 0, 1, 4, 3, 0, 0), "ovl_advance");
        mem_in(1'b1, 1'b0, 1'b0);
        step(mk(K_NORM, 1, 0, 4, 3, 0, 0), "ovl_flags_clear");

        // Data response first, instruction later.
        mem_in(1'b0, 1'b1, 1'b1);
        step(mk(K_STALL, 1, 1, 4, 3, 0, 0), "dfirst_dresp");
        mem_in(1'b0, 1'b1, 1'b0);
        step(mk(K_STALL, 1, 0, 5, 3, 0, 0), "dfirst_memdone");
        mem_in(1'b1, 1'b1, 1'b0);
        step(mk(K_NORM, 1, 0, 6, 3, 0, 0), "dfirst_advance");
        mem_in(1'b1, 1'b1, 1'b1);
        step(mk(K_NORM, 1, 1, 6, 3, 0, 0), "single_cycle_hit");

        // Load-use hazards.
        mem_in(1'b1, 1'b0, 1'b0);
        haz(1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 5'd5, 5'd0, 1'b1, 1'b0);
        step(mk(K_LUSE, 1, 0, 6, 3, 0, 0), "luse_rs1");
        haz(1'b1, 1'b0, 1'b1, 5'd0, 1'b1, 5'd0, 5'd0, 1'b1, 1'b0);
        step(mk(K_NORM, 1, 0, 6, 3, 1, 0), "luse_rd_zero");
        haz(1'b1, 1'b0, 1'b1, 5'd7, 1'b1, 5'd3, 5'd7, 1'b0, 1'b1);
        step(mk(K_LUSE, 1, 0, 6, 3, 1, 0), "luse_rs2");
        mem_in(1'b0, 1'b0, 1'b0);
        step(mk(K_STALL, 1, 0, 6, 3, 2, 0), "luse_deferred");
        mem_in(1'b1, 1'b0, 1'b0);
        step(mk(K_LUSE, 1, 0, 7, 3, 2, 0), "luse_after_stall");

        // Mispredict overrides a simultaneous load-use.
        haz(1'b1, 1'b1, 1'b1, 5'd7, 1'b1, 5'd3, 5'd7, 1'b0, 1'b1);
        step(mk(K_FLUSH, 1, 0, 7, 3, 3, 0), "flush_over_luse");
        haz(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
        step(mk(K_NORM, 1, 0, 7, 3, 3, 1), "after_flush");

        // Async reset while an instruction response is held.
        mem_in(1'b1, 1'b1, 1'b0);
        step(mk(K_STALL, 1, 1, 7, 3, 3, 1), "rst_pre_stall");
        mem_in(1'b0, 1'b1, 1'b0);
        push_exp(mk(K_STALL, 0, 1, 7, 4, 3, 1), "rst_ifdone_held");
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({imem_req, pc_load, ifid_load, idex_load, exmem_load, memwb_load,
             perf_imiss, perf_dmiss, perf_bubble, perf_flush} !== {1'b1, 5'b0, 128'b0}) begin
            errors++;
            $display("FAIL async_rst imem_req=%b loads=%b perf=%h/%h/%h/%h exp imem_req=1 loads=0 perf=0",
                     imem_req, {pc_load, ifid_load, idex_load, exmem_load, memwb_load},
                     perf_imiss, perf_dmiss, perf_bubble, perf_flush);
        end
        #1;
        rst = 1'b0;
        tick();
        step(mk(K_STALL, 1, 1, 1, 0, 0, 0), "rst_discarded");
        mem_in(1'b1, 1'b1, 1'b1);
        step(mk(K_NORM, 1, 1, 2, 0, 0, 0), "rst_recover");

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1);
    end
endmodule

`default_nettype wire
